rf_wb_arbiter: RTL and testbench

- Owns the single register-file write port.
- Shares the port between the in-order pipeline writeback (after the Mem2Reg select) and a long-latency unit (LU) such as a multi-cycle divider or CP0 return path.
- Buffers LU results in a small FIFO and grants the port with pipeline priority plus anti-starvation.
- Drives the RF write port and debug trace, and exports a busy mask for the ID-stage interlock.

---
 rtl/cpu_wb_pkg.sv | 20 ++
 rtl/wb_lu_fifo.sv | 68 ++++++
 rtl/rf_wb_arbiter.sv | 120 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_wb_pkg.sv
// Shared writeback types for the register-file write port and its LU result buffer.
package cpu_wb_pkg;

  localparam int XLEN  = 32;
  localparam int RF_AW = 5;

  typedef struct packed {
    logic [RF_AW-1:0] wa;
    logic [XLEN-1:0]  wd;
    logic [XLEN-1:0]  pc;
  } wb_entry_t;

  function automatic logic [XLEN-1:0] onehot32(input logic [RF_AW-1:0] idx);
    logic [XLEN-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_lu_fifo.sv
// In-order FIFO for long-latency unit results; exposes per-entry valid/wa for the busy mask.
module wb_lu_fifo
  import cpu_wb_pkg::*;
#(
  parameter int LU_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            push,
  input  wb_entry_t                       push_entry,
  input  logic                            pop,
  output wb_entry_t                       head,
  output logic                            full,
  output logic                            empty,
  output logic [LU_DEPTH-1:0]             ent_vld,
  output logic [LU_DEPTH-1:0][RF_AW-1:0]  ent_wa
);

  localparam int PW = $clog2(LU_DEPTH);

  wb_entry_t           mem [LU_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [LU_DEPTH-1:0] vld;
  logic                push_ok;
  logic                pop_ok;

  assign full    = &vld;
  assign empty   = ~|vld;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // A push and a pop in the same cycle never touch the same slot: pop needs a
  // non-empty FIFO and push a non-full one, so wr_ptr != rd_ptr.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld    <= '0;
    end else begin
      if (push_ok) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  assign head    = mem[rd_ptr];
  assign ent_vld = vld;

  always_comb begin
    ent_wa = '0;
    for (int i = 0; i < LU_DEPTH; i++) begin
      ent_wa[i] = mem[i].wa;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, buffered LU
// results are forced through after STARVE_MAX denied cycles.
module rf_wb_arbiter
  import cpu_wb_pkg::*;
#(
  parameter int LU_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pipe_valid_i,
  input  logic             pipe_we_i,
  input  logic [RF_AW-1:0] pipe_wa_i,
  input  logic [XLEN-1:0]  pipe_wd_i,
  input  logic [XLEN-1:0]  pipe_pc_i,
  output logic             pipe_stall_o,
  input  logic             lu_valid_i,
  output logic             lu_ready_o,
  input  logic [RF_AW-1:0] lu_wa_i,
  input  logic [XLEN-1:0]  lu_wd_i,
  input  logic [XLEN-1:0]  lu_pc_i,
  output logic             rf_we_o,
  output logic [RF_AW-1:0] rf_wa_o,
  output logic [XLEN-1:0]  rf_wd_o,
  output logic [XLEN-1:0]  debug_pc_o,
  output logic [XLEN-1:0]  busy_mask_o
);

  localparam int              SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] c);
    return (c == STARVE_LIM) ? c : c + SW'(1);
  endfunction

  wb_entry_t                      lu_entry;
  wb_entry_t                      head;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic [LU_DEPTH-1:0]            ent_vld;
  logic [LU_DEPTH-1:0][RF_AW-1:0] ent_wa;
  logic                           pipe_req;
  logic                           lu_head;
  logic                           grant_lu;
  logic                           grant_pipe;
  logic                           lu_push;
  logic [SW-1:0]                  starve_cnt;
  logic [XLEN-1:0]                busy_mask;

  assign lu_entry = '{wa: lu_wa_i, wd: lu_wd_i, pc: lu_pc_i};
  assign lu_push  = lu_valid_i & lu_ready_o;

  wb_lu_fifo #(
    .LU_DEPTH (LU_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (lu_push),
    .push_entry (lu_entry),
    .pop        (grant_lu),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .ent_vld    (ent_vld),
    .ent_wa     (ent_wa)
  );

  // Requests that do not write a real register never occupy the port.
  assign pipe_req     = pipe_valid_i & pipe_we_i & (pipe_wa_i != '0);
  assign lu_head      = ~fifo_empty;
  assign grant_lu     = lu_head & (~pipe_req | (starve_cnt == STARVE_LIM));
  assign grant_pipe   = pipe_req & ~grant_lu;
  assign pipe_stall_o = pipe_req & grant_lu;
  assign lu_ready_o   = ~fifo_full;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (fifo_empty || grant_lu) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= sat_inc(starve_cnt);
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we_o    <= 1'b0;
      rf_wa_o    <= '0;
      rf_wd_o    <= '0;
      debug_pc_o <= '0;
    end else if (grant_pipe) begin
      rf_we_o    <= 1'b1;
      rf_wa_o    <= pipe_wa_i;
      rf_wd_o    <= pipe_wd_i;
      debug_pc_o <= pipe_pc_i;
    end else if (grant_lu) begin
      rf_we_o    <= (head.wa != '0);
      rf_wa_o    <= head.wa;
      rf_wd_o    <= head.wd;
      debug_pc_o <= head.pc;
    end else begin
      rf_we_o    <= 1'b0;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < LU_DEPTH; i++) begin
      if (ent_vld[i]) begin
        busy_mask = busy_mask | onehot32(ent_wa[i]);
      end
    end
    busy_mask[0] = 1'b0;
  end

  assign busy_mask_o = busy_mask;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_rf_wb_arbiter;
  import cpu_wb_pkg::*;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pipe_valid_i, pipe_we_i;
  logic [4:0]  pipe_wa_i;
  logic [31:0] pipe_wd_i, pipe_pc_i;
  logic        pipe_stall_o;
  logic        lu_valid_i, lu_ready_o;
  logic [4:0]  lu_wa_i;
  logic [31:0] lu_wd_i, lu_pc_i;
  logic        rf_we_o;
  logic [4:0]  rf_wa_o;
  logic [31:0] rf_wd_o, debug_pc_o, busy_mask_o;

  int total = 0;
  int bad   = 0;

  rf_wb_arbiter #(.LU_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pipe_valid_i (pipe_valid_i),
    .pipe_we_i    (pipe_we_i),
    .pipe_wa_i    (pipe_wa_i),
    .pipe_wd_i    (pipe_wd_i),
    .pipe_pc_i    (pipe_pc_i),
    .pipe_stall_o (pipe_stall_o),
    .lu_valid_i   (lu_valid_i),
    .lu_ready_o   (lu_ready_o),
    .lu_wa_i      (lu_wa_i),
    .lu_wd_i      (lu_wd_i),
    .lu_pc_i      (lu_pc_i),
    .rf_we_o      (rf_we_o),
    .rf_wa_o      (rf_wa_o),
    .rf_wd_o      (rf_wd_o),
    .debug_pc_o   (debug_pc_o),
    .busy_mask_o  (busy_mask_o)
  );

  always #5 clk = ~clk;

  // Reference model: pending LU results as a queue, port decision from the arbitration rules.
  wb_entry_t   mq[$];
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd, m_pc;
  bit          e_glu, e_gpipe, e_stall, e_ready;
  logic [31:0] e_mask;

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_we = 1'b0; m_wa = '0; m_wd = '0; m_pc = '0;
  endtask

  task automatic model_comb();
    bit req;
    req     = pipe_valid_i && pipe_we_i && (pipe_wa_i != 5'd0);
    e_glu   = (mq.size() > 0) && (!req || m_starve == SMAX);
    e_gpipe = req && !e_glu;
    e_stall = req && e_glu;
    e_ready = mq.size() < DEPTH;
    e_mask  = '0;
    foreach (mq[i]) e_mask = e_mask | (32'h1 << mq[i].wa);
    e_mask[0] = 1'b0;
  endtask

  task automatic model_clk();
    bit        had;
    wb_entry_t h;
    had = (mq.size() != 0);
    if (e_gpipe) begin
      m_we = 1'b1; m_wa = pipe_wa_i; m_wd = pipe_wd_i; m_pc = pipe_pc_i;
    end else if (e_glu) begin
      h = mq.pop_front();
      m_we = (h.wa != 5'd0); m_wa = h.wa; m_wd = h.wd; m_pc = h.pc;
    end else begin
      m_we = 1'b0;
    end
    if (!had || e_glu) m_starve = 0;
    else if (m_starve < SMAX) m_starve = m_starve + 1;
    if (lu_valid_i && e_ready) begin
      h.wa = lu_wa_i; h.wd = lu_wd_i; h.pc = lu_pc_i;
      mq.push_back(h);
    end
  endtask

  // Called at a falling edge: clocks DUT and model once, returns at the next falling edge.
  task automatic tick();
    model_comb();
    @(posedge clk);
    model_clk();
    @(negedge clk);
  endtask

  task automatic drive_pipe(input bit v, input bit we, input logic [4:0] wa,
                            input logic [31:0] wd, input logic [31:0] pc);
    pipe_valid_i = v; pipe_we_i = we; pipe_wa_i = wa; pipe_wd_i = wd; pipe_pc_i = pc;
  endtask

  task automatic drive_lu(input bit v, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [31:0] pc);
    lu_valid_i = v; lu_wa_i = wa; lu_wd_i = wd; lu_pc_i = pc;
  endtask

  task automatic idle();
    drive_pipe(0, 0, 5'd0, 32'd0, 32'd0);
    drive_lu(0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    #2;
    total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b exp=0", rf_we_o); end
    total++; if (rf_wa_o !== 5'd0) begin bad++; $display("FAIL reset_rf_wa got=%h exp=0", rf_wa_o); end
    total++; if (rf_wd_o !== 32'd0) begin bad++; $display("FAIL reset_rf_wd got=%h exp=0", rf_wd_o); end
    total++; if (debug_pc_o !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", debug_pc_o); end
    total++; if (busy_mask_o !== 32'd0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy_mask_o); end
    total++; if (pipe_stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", pipe_stall_o); end
    total++; if (lu_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", lu_ready_o); end
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic test_pipe_only();
    drive_pipe(1, 1, 5'd5, 32'h1234, 32'hBFC00010);
    #1;
    total++; if (pipe_stall_o !== 1'b0) begin bad++; $display("FAIL pipe_stall got=%b exp=0", pipe_stall_o); end
    tick();
    total++; if (rf_we_o !== 1'b1) begin bad++; $display("FAIL pipe_we got=%b exp=1", rf_we_o); end
    total++; if (rf_wa_o !== 5'd5) begin bad++; $display("FAIL pipe_wa got=%0d exp=5", rf_wa_o); end
    total++; if (rf_wd_o !== 32'h1234) begin bad++; $display("FAIL pipe_wd got=%h exp=1234", rf_wd_o); end
    total++; if (debug_pc_o !== 32'hBFC00010) begin bad++; $display("FAIL pipe_pc got=%h exp=bfc00010", debug_pc_o); end
    idle();
    tick();
    total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL pipe_idle_we got=%b exp=0", rf_we_o); end
    total++; if ({rf_wa_o, rf_wd_o} !== {5'd5, 32'h1234}) begin
      bad++; $display("FAIL pipe_hold got=%0d/%h exp=5/1234", rf_wa_o, rf_wd_o);
    end
  endtask

  task automatic test_lu_idle();
    drive_lu(1, 5'd8, 32'hDEADBEEF, 32'h80000100);
    #1;
    total++; if (lu_ready_o !== 1'b1) begin bad++; $display("FAIL lu_ready got=%b exp=1", lu_ready_o); end
    tick();
    idle();
    #1;
    total++; if (busy_mask_o !== 32'h100) begin bad++; $display("FAIL lu_busy got=%h exp=100", busy_mask_o); end
    total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL lu_early_we got=%b exp=0", rf_we_o); end
    tick();
    total++; if ({rf_we_o, rf_wa_o, rf_wd_o, debug_pc_o} !== {1'b1, 5'd8, 32'hDEADBEEF, 32'h80000100}) begin
      bad++; $display("FAIL lu_write got=%b/%0d/%h/%h exp=1/8/deadbeef/80000100", rf_we_o, rf_wa_o, rf_wd_o, debug_pc_o);
    end
    total++; if (busy_mask_o !== 32'h0) begin bad++; $display("FAIL lu_busy_clr got=%h exp=0", busy_mask_o); end
  endtask

  task automatic test_starvation();
    int k;
    k = 0;
    for (int c = 0; c < 7; c++) begin
      drive_pipe(1, 1, 5'(10 + k), 32'h1000 + k, 32'hBFC00100 + 4 * k);
      drive_lu(c == 0, 5'd3, 32'hCAFE0003, 32'h80000200);
      #1;
      total++; if (pipe_stall_o !== (c == 5)) begin
        bad++; $display("FAIL starve_stall c=%0d got=%b exp=%b", c, pipe_stall_o, c == 5);
      end
      if (c >= 1 && c <= 5) begin
        total++; if (busy_mask_o !== 32'h8) begin bad++; $display("FAIL starve_busy c=%0d got=%h exp=8", c, busy_mask_o); end
      end
      tick();
      if (c == 5) begin
        total++; if ({rf_we_o, rf_wa_o, rf_wd_o} !== {1'b1, 5'd3, 32'hCAFE0003}) begin
          bad++; $display("FAIL starve_lu got=%b/%0d/%h exp=1/3/cafe0003", rf_we_o, rf_wa_o, rf_wd_o);
        end
      end else begin
        total++; if ({rf_we_o, rf_wa_o, rf_wd_o} !== {1'b1, 5'(10 + k), 32'h1000 + k}) begin
          bad++; $display("FAIL starve_pipe c=%0d got=%b/%0d/%h exp=1/%0d/%h", c, rf_we_o, rf_wa_o, rf_wd_o, 10 + k, 32'h1000 + k);
        end
        k++;
      end
    end
    idle();
  endtask

  task automatic test_full_fifo();
    int k;
    bit exp_rdy;
    k = 0;
    for (int c = 0; c < 7; c++) begin
      drive_pipe(1, 1, 5'(16 + k), 32'h2000 + k, 32'hBFC00200 + 4 * k);
      if (c == 0)      drive_lu(1, 5'd6, 32'hA0, 32'h80000300);
      else if (c == 1) drive_lu(1, 5'd7, 32'hA1, 32'h80000304);
      else             drive_lu(1, 5'd9, 32'hA2, 32'h80000308);
      exp_rdy = (c < 2) || (c >= 6);
      #1;
      total++; if (lu_ready_o !== exp_rdy) begin bad++; $display("FAIL full_ready c=%0d got=%b exp=%b", c, lu_ready_o, exp_rdy); end
      total++; if (pipe_stall_o !== (c == 5)) begin bad++; $display("FAIL full_stall c=%0d got=%b exp=%b", c, pipe_stall_o, c == 5); end
      tick();
      total++; if ({rf_we_o, rf_wa_o, rf_wd_o, debug_pc_o} !== {m_we, m_wa, m_wd, m_pc}) begin
        bad++; $display("FAIL full_rf c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, rf_we_o, rf_wa_o, rf_wd_o, m_we, m_wa, m_wd);
      end
      if (c != 5) k++;
    end
    idle();
    #1;
    total++; if (busy_mask_o !== 32'h280) begin bad++; $display("FAIL full_busy got=%h exp=280", busy_mask_o); end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if ({rf_we_o, rf_wa_o, rf_wd_o, debug_pc_o} !== {m_we, m_wa, m_wd, m_pc}) begin
        bad++; $display("FAIL full_drain c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, rf_we_o, rf_wa_o, rf_wd_o, m_we, m_wa, m_wd);
      end
    end
    total++; if ({busy_mask_o, lu_ready_o} !== {32'h0, 1'b1}) begin
      bad++; $display("FAIL full_empty got=%h/%b exp=0/1", busy_mask_o, lu_ready_o);
    end
  endtask

  task automatic test_zero_reg();
    drive_pipe(1, 1, 5'd0, 32'h55, 32'hBFC00300);
    #1;
    total++; if (pipe_stall_o !== 1'b0) begin bad++; $display("FAIL zero_stall got=%b exp=0", pipe_stall_o); end
    tick();
    total++; if (rf_we_o !== 1'b0) begin bad++; $display("FAIL zero_pipe_we got=%b exp=0", rf_we_o); end
    drive_lu(1, 5'd0, 32'h77, 32'h80000400);
    tick();
    drive_lu(0, 5'd0, 32'd0, 32'd0);
    #1;
    total++; if (busy_mask_o !== 32'h0) begin bad++; $display("FAIL zero_busy got=%h exp=0", busy_mask_o); end
    total++; if (pipe_stall_o !== 1'b0) begin bad++; $display("FAIL zero_stall2 got=%b exp=0", pipe_stall_o); end
    tick();
    total++; if ({rf_we_o, rf_wa_o, rf_wd_o} !== {1'b0, 5'd0, 32'h77}) begin
      bad++; $display("FAIL zero_lu got=%b/%0d/%h exp=0/0/77", rf_we_o, rf_wa_o, rf_wd_o);
    end
    total++; if (lu_ready_o !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b exp=1", lu_ready_o); end
    idle();
  endtask

  task automatic test_random();
    bit held;
    held = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (!held) begin
        drive_pipe($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, 5'($urandom_range(0, 31)),
                   $urandom, $urandom);
      end
      drive_lu($urandom_range(0, 9) < 4, 5'($urandom_range(0, 31)), $urandom, $urandom);
      model_comb();
      #1;
      total++; if ({pipe_stall_o, lu_ready_o} !== {e_stall, e_ready}) begin
        bad++; $display("FAIL rnd_ctl c=%0d got=%b%b exp=%b%b", c, pipe_stall_o, lu_ready_o, e_stall, e_ready);
      end
      total++; if (busy_mask_o !== e_mask) begin bad++; $display("FAIL rnd_busy c=%0d got=%h exp=%h", c, busy_mask_o, e_mask); end
      held = e_stall;
      tick();
      total++; if ({rf_we_o, rf_wa_o, rf_wd_o, debug_pc_o} !== {m_we, m_wa, m_wd, m_pc}) begin
        bad++; $display("FAIL rnd_rf c=%0d got=%b/%0d/%h/%h exp=%b/%0d/%h/%h", c, rf_we_o, rf_wa_o, rf_wd_o, debug_pc_o,
                        m_we, m_wa, m_wd, m_pc);
      end
    end
    idle();
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2; c++) begin
      drive_pipe(1, 1, 5'(20 + c), 32'h3000 + c, 32'hBFC00400 + 4 * c);
      drive_lu(1, 5'(12 + c), 32'hB0 + c, 32'h80000500 + 4 * c);
      tick();
    end
    drive_lu(0, 5'd0, 32'd0, 32'd0);
    #1;
    total++; if (busy_mask_o !== 32'h3000) begin bad++; $display("FAIL mid_busy_pre got=%h exp=3000", busy_mask_o); end
    #1 resetn = 1'b0;
    #1;
    total++; if ({rf_we_o, rf_wa_o, rf_wd_o, debug_pc_o} !== 70'd0) begin
      bad++; $display("FAIL mid_rf got=%b/%0d/%h/%h exp=0", rf_we_o, rf_wa_o, rf_wd_o, debug_pc_o);
    end
    total++; if ({busy_mask_o, pipe_stall_o, lu_ready_o} !== {32'h0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL mid_ctl got=%h/%b/%b exp=0/0/1", busy_mask_o, pipe_stall_o, lu_ready_o);
    end
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    idle();
    tick();
    total++; if ({rf_we_o, busy_mask_o} !== {1'b0, 32'h0}) begin
      bad++; $display("FAIL mid_discard got=%b/%h exp=0/0", rf_we_o, busy_mask_o);
    end
  endtask

  initial begin
    resetn = 1'b1;
    idle();
    model_reset();
    test_reset();
    test_pipe_only();
    test_lu_idle();
    test_starvation();
    test_full_fifo();
    test_zero_reg();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
